// File: rtl/dmem_mmio_ctrl.sv
// Data-memory + UART MMIO controller: byte RAM, UART TX FIFO, 1-cycle registered responses.
// Optional error logging (ERRADDR register, STATUS bit2) enabled by the DMEM_ERRLOG_EN macro.
module dmem_mmio_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter int unsigned DMEM_BYTES = 131072,
  parameter logic [31:0] MMIO_BASE  = 32'h2000_0000,
  parameter int unsigned TXQ_DEPTH  = 8,
  parameter string       INIT_FILE  = "data.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DMEM_BYTES);
  localparam int unsigned PW = $clog2(TXQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0] mem [DMEM_BYTES];

  logic [7:0]    txq_q [TXQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          resp_valid_q, resp_err_q;
  logic [31:0]   resp_rdata_q;

  logic [31:0]   ram_off;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic          in_ram, is_word, misalign, hit_txd, hit_stat;
  logic          fifo_full, fifo_empty, err_bit;
  logic          acc_c, push_c, pop_c, fault_c, ram_we_c;
  logic [31:0]   rd_c, load_c, status_c;

  // Address decode
  assign ram_off    = req_addr - DMEM_BASE;
  assign in_ram     = ram_off < 32'(DMEM_BYTES);
  assign is_word    = req_size[1];
  assign misalign   = (req_size == 2'b01 && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00);
  assign hit_txd    = req_addr == MMIO_BASE;
  assign hit_stat   = req_addr == MMIO_BASE + 32'd4;

  assign idx0 = ram_off[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign b0 = mem[idx0];
  assign b1 = mem[idx1];
  assign b2 = mem[idx2];
  assign b3 = mem[idx3];

  assign fifo_full  = count_q == CW'(TXQ_DEPTH);
  assign fifo_empty = count_q == '0;
  assign status_c   = {16'h0, 8'(count_q), 5'h0, err_bit, fifo_empty, fifo_full};

  // Only a TXDATA store against a full FIFO back-pressures the request port
  assign req_ready = !(req_we && hit_txd && is_word && fifo_full);
  assign acc_c     = req_valid && req_ready;
  assign pop_c     = !fifo_empty && tx_ready;

`ifdef DMEM_ERRLOG_EN
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] erraddr_q, erraddr_d;
  logic        hit_erraddr, clr_c;
  assign hit_erraddr = req_addr == MMIO_BASE + 32'd8;
  assign err_bit     = err_sticky_q;
`else
  assign err_bit     = 1'b0;
`endif

  // Load data extraction, little-endian
  always_comb begin
    load_c = '0;
    case (req_size)
      2'b00:   load_c = {{24{req_signed & b0[7]}}, b0};
      2'b01:   load_c = {{16{req_signed & b1[7]}}, b1, b0};
      default: load_c = {b3, b2, b1, b0};
    endcase
  end

  // Request classification and response data
  always_comb begin
    fault_c  = 1'b0;
    rd_c     = '0;
    ram_we_c = 1'b0;
    push_c   = 1'b0;
`ifdef DMEM_ERRLOG_EN
    clr_c    = 1'b0;
`endif
    if (in_ram) begin
      if (misalign)    fault_c  = 1'b1;
      else if (req_we) ram_we_c = 1'b1;
      else             rd_c     = load_c;
    end else if (hit_txd && is_word) begin
      push_c = req_we && acc_c;
    end else if (hit_stat && is_word) begin
      if (!req_we) rd_c = status_c;
`ifdef DMEM_ERRLOG_EN
    end else if (hit_erraddr && is_word) begin
      if (req_we) clr_c = 1'b1;
      else        rd_c  = erraddr_q;
`endif
    end else begin
      fault_c = 1'b1;
    end
  end

  // FIFO pointer/count next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef DMEM_ERRLOG_EN
  // A fault always wins over a coincident clear
  always_comb begin
    err_sticky_d = err_sticky_q;
    erraddr_d    = erraddr_q;
    if (acc_c && clr_c) begin
      err_sticky_d = 1'b0;
      erraddr_d    = '0;
    end
    if (acc_c && fault_c && (!err_sticky_q || clr_c)) begin
      err_sticky_d = 1'b1;
      erraddr_d    = req_addr;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (acc_c && ram_we_c) begin
      mem[idx0] <= req_wdata[7:0];
      if (req_size != 2'b00) mem[idx1] <= req_wdata[15:8];
      if (is_word) begin
        mem[idx2] <= req_wdata[23:16];
        mem[idx3] <= req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) txq_q[wr_ptr_q] <= req_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef DMEM_ERRLOG_EN
      err_sticky_q <= 1'b0;
      erraddr_q    <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= acc_c;
      resp_err_q   <= acc_c && fault_c;
      resp_rdata_q <= acc_c ? rd_c : 32'h0;
`ifdef DMEM_ERRLOG_EN
      err_sticky_q <= err_sticky_d;
      erraddr_q    <= erraddr_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign tx_valid   = !fifo_empty;
  assign tx_data    = txq_q[rd_ptr_q];

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Self-checking bench for dmem_mmio_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue/array reference model.
module tb_dmem_mmio_ctrl;

  localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
  localparam int unsigned DMEM_BYTES = 131072;
  localparam logic [31:0] MMIO_BASE  = 32'h2000_0000;
  localparam int unsigned TXQ_DEPTH  = 8;
  localparam int          WIN        = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_err, tx_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_mmio_ctrl #(
    .DMEM_BASE(DMEM_BASE), .DMEM_BYTES(DMEM_BYTES), .MMIO_BASE(MMIO_BASE),
    .TXQ_DEPTH(TXQ_DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: RAM window bytes, FIFO as a queue, expected response
  logic [7:0]  m_ram [WIN];
  logic [7:0]  m_q [$];
  logic        m_sticky = 1'b0;
  logic [31:0] m_erraddr = '0;
  logic        exp_rv = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rd = '0;

  function automatic logic m_ready();
    return !(req_we && req_addr == MMIO_BASE && req_size[1] && m_q.size() == TXQ_DEPTH);
  endfunction

  task automatic model_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] wd);
    bit          fault;
    logic [31:0] rd, st;
    int          nb, off;
    fault = 0;
    rd    = '0;
    nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    st    = {16'h0, 8'(m_q.size()), 5'h0, 1'b0, m_q.size() == 0, m_q.size() == TXQ_DEPTH};
`ifdef DMEM_ERRLOG_EN
    st[2] = m_sticky;
`endif
    if ({32'h0, a} >= {32'h0, DMEM_BASE} && {32'h0, a} < {32'h0, DMEM_BASE} + 64'(DMEM_BYTES)) begin
      if ((a % nb) != 0) fault = 1;
      else begin
        off = int'(a - DMEM_BASE);
        if (off + nb <= WIN) begin
          for (int k = 0; k < nb; k++) begin
            if (we) m_ram[off + k] = wd[8*k +: 8];
            else    rd = rd | (32'(m_ram[off + k]) << (8 * k));
          end
          if (!we && nb < 4 && sg && rd[8*nb-1]) rd = rd | ~((32'd1 << (8 * nb)) - 32'd1);
        end
      end
    end else if (a == MMIO_BASE && nb == 4) begin
      if (we) m_q.push_back(wd[7:0]);
    end else if (a == MMIO_BASE + 32'd4 && nb == 4) begin
      if (!we) rd = st;
`ifdef DMEM_ERRLOG_EN
    end else if (a == MMIO_BASE + 32'd8 && nb == 4) begin
      if (we) begin m_sticky = 1'b0; m_erraddr = '0; end
      else rd = m_erraddr;
`endif
    end else begin
      fault = 1;
    end
    if (fault) begin
      rd = '0;
      if (!m_sticky) begin m_sticky = 1'b1; m_erraddr = a; end
    end
    exp_err = fault;
    exp_rd  = rd;
  endtask

  // Compare process: outputs checked at every negedge, model advanced for the next edge
  always @(negedge clk) begin
    bit acc, pop;
    if (!rst_n) begin
      m_q.delete();
      m_sticky  = 1'b0;
      m_erraddr = '0;
      exp_rv    = 1'b0;
      exp_err   = 1'b0;
      exp_rd    = '0;
    end else begin
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      check("resp_err", 32'(resp_err), 32'(exp_err));
      check("resp_rdata", resp_rdata, exp_rd);
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
      check("req_ready", 32'(req_ready), 32'(m_ready()));
      acc = req_valid && m_ready();
      pop = (m_q.size() != 0) && tx_ready;
      exp_rv  = acc;
      exp_err = 1'b0;
      exp_rd  = '0;
      if (acc) model_req(req_we, req_addr, req_size, req_signed, req_wdata);
      if (pop) void'(m_q.pop_front());
    end
  end

  // Drive a request starting at posedge+2; returns at posedge+2 after the accepting edge
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd);
    int   cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_signed = sg; req_wdata = wd;
    while (!got) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #2;
      cyc++;
      if (!got && cyc > 3) tx_ready = 1'b1;
      if (!got && cyc > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_timeout addr=%h waited=%0d required_accept=1", a, cyc);
        got = 1'b1;
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          sel;

    #22 rst_n = 1'b1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    @(posedge clk); #2;

    for (int i = 0; i < WIN / 4; i++) issue(1'b1, DMEM_BASE + 32'(4 * i), 2'b10, 1'b0, $urandom);

    // Sub-word loads with sign/zero extension
    issue(1'b1, 32'h1000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h1000_0013, 2'b00, 1'b1, 32'h0);
    check("lb_signed_valid", 32'(resp_valid), 32'd1);
    check("lb_signed", resp_rdata, 32'hFFFF_FFDE);
    issue(1'b0, 32'h1000_0010, 2'b01, 1'b0, 32'h0);
    check("lhu", resp_rdata, 32'h0000_BEEF);
    idle(2);

    // Back-to-back byte store then word load
    issue(1'b1, 32'h1000_0000, 2'b10, 1'b0, 32'h1122_3344);
    idle(1);
    issue(1'b1, 32'h1000_0001, 2'b00, 1'b0, 32'h0000_005A);
    check("b2b_first_valid", 32'(resp_valid), 32'd1);
    issue(1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'h0);
    check("b2b_second_valid", 32'(resp_valid), 32'd1);
    check("sb_then_lw", resp_rdata, 32'h1122_5A44);
    idle(1);

    // Faults: misaligned and out of range
    issue(1'b0, 32'h1000_0003, 2'b01, 1'b0, 32'h0);
    check("misaligned_err", 32'(resp_err), 32'd1);
    check("misaligned_rdata", resp_rdata, 32'd0);
    issue(1'b1, 32'h1002_0000, 2'b10, 1'b0, 32'hCAFE_F00D);
    check("oor_err", 32'(resp_err), 32'd1);
    issue(1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'h0);
    check("oor_ram_unchanged", resp_rdata, 32'h1122_5A44);
`ifdef DMEM_ERRLOG_EN
    issue(1'b0, MMIO_BASE + 32'd8, 2'b10, 1'b0, 32'h0);
    check("erraddr", resp_rdata, 32'h1000_0003);
    issue(1'b1, MMIO_BASE + 32'd8, 2'b10, 1'b0, 32'h0);
`endif
    idle(2);

    // FIFO fill, stall, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(1'b1, MMIO_BASE, 2'b10, 1'b0, 32'hA0 + 32'(i));
    issue(1'b0, MMIO_BASE + 32'd4, 2'b10, 1'b0, 32'h0);
    check("status_full", resp_rdata, 32'h0000_0801);
    req_valid = 1'b1; req_we = 1'b1; req_addr = MMIO_BASE; req_size = 2'b10; req_wdata = 32'hA8;
    @(negedge clk);
    check("ninth_stalled", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    tx_ready = 1'b1;
    @(negedge clk);
    check("stalled_during_pop", 32'(req_ready), 32'd0);
    check("first_byte", 32'(tx_data), 32'hA0);
    @(posedge clk); #2;
    @(negedge clk);
    check("accept_after_pop", 32'(req_ready), 32'd1);
    @(posedge clk); #2;
    idle(12);
    check("drained", 32'(tx_valid), 32'd0);

    // Reset with bytes queued and a response in flight
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, MMIO_BASE, 2'b10, 1'b0, 32'h30 + 32'(i));
    issue(1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'h0);
    check("pending_resp", 32'(resp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    issue(1'b0, MMIO_BASE + 32'd4, 2'b10, 1'b0, 32'h0);
    check("status_after_reset", resp_rdata, 32'h0000_0002);
    idle(1);

    // Randomized traffic across RAM window, out-of-range and MMIO
    for (int it = 0; it < 500; it++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      sz  = 2'($urandom_range(0, 3));
      d   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = DMEM_BASE + 32'($urandom_range(0, WIN - 1));
        4:          a = DMEM_BASE - 32'($urandom_range(1, 8));
        5:          a = DMEM_BASE + 32'(DMEM_BYTES) + 32'($urandom_range(0, 8));
        6, 7:       a = MMIO_BASE;
        default:    a = MMIO_BASE + 32'(4 * $urandom_range(1, 3));
      endcase
      if (sel >= 6 && $urandom_range(0, 3) != 0) sz = 2'b10;
      issue($urandom_range(0, 1) == 1, a, sz, $urandom_range(0, 1) == 1, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    tx_ready = 1'b1;
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
